// File: rtl/tally_pkg.sv
// Shared types and constants for the capture/tally path (controller and reporter).
package tally_pkg;
    localparam int CNT_W_DEF   = 8;
    localparam int NUM_OPS_DEF = 4;
    localparam int IDX_W       = 3;
    localparam logic [IDX_W-1:0] IDX_TRAILER = 3'd4;

    typedef enum logic [1:0] {IDLE, SEND, CLEAR, WAIT_LOW} state_t;
endpackage

// File: rtl/tally_snapshot.sv
// Snapshot register bank for the tally counters, loaded on a strobe and read back by index.
module tally_snapshot
    import tally_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int NUM_OPS = NUM_OPS_DEF
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     load,
    input  logic [NUM_OPS*CNT_W-1:0] count_bus,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [CNT_W-1:0]         rd_data
);
    logic [NUM_OPS-1:0][CNT_W-1:0] snap;

    always_ff @(posedge clock or posedge rst) begin
        if (rst)       snap <= '0;
        else if (load) snap <= count_bus;
    end

    // Indices past the bank (e.g. the trailer slot) read as zero.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_OPS; k++)
            if (rd_idx == IDX_W'(k)) rd_data = snap[k];
    end
endmodule

// File: rtl/tally_reporter.sv
// Snapshots the tally counters on `full`, streams them over valid/ready, then pulses `clear`.
// Optional trailer word carrying the counter sum: define TALLY_REPORTER_SUM_EN.
module tally_reporter
    import tally_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int NUM_OPS = NUM_OPS_DEF
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     full,
    input  logic [NUM_OPS*CNT_W-1:0] count_bus,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [CNT_W-1:0]         out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last,
    output logic                     clear,
    output logic                     busy
);
`ifdef TALLY_REPORTER_SUM_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_TRAILER;
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);
`endif

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               load;
    logic [CNT_W-1:0]   rd_data;

    assign load    = (state == IDLE) && full;
    assign out_idx = idx;

    tally_snapshot #(.CNT_W(CNT_W), .NUM_OPS(NUM_OPS)) u_snapshot (
        .clock     (clock),
        .rst       (rst),
        .load      (load),
        .count_bus (count_bus),
        .rd_idx    (idx),
        .rd_data   (rd_data)
    );

`ifdef TALLY_REPORTER_SUM_EN
    // Sum is captured alongside the snapshot, so it always matches the reported words.
    logic [CNT_W-1:0] bus_sum, sum_q;

    always_comb begin
        bus_sum = '0;
        for (int k = 0; k < NUM_OPS; k++)
            bus_sum = bus_sum + count_bus[k*CNT_W +: CNT_W];
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst)       sum_q <= '0;
        else if (load) sum_q <= bus_sum;
    end

    assign out_data = (idx == IDX_TRAILER) ? sum_q : rd_data;
`else
    assign out_data = rd_data;
`endif

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            clear     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (full) begin
                    state     <= SEND;
                    idx       <= '0;
                    out_valid <= 1'b1;
                    out_last  <= (LAST_IDX == '0);
                    busy      <= 1'b1;
                end
                SEND: if (out_ready) begin
                    if (out_last) begin
                        state     <= CLEAR;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        clear     <= 1'b1;
                    end else begin
                        idx      <= idx + 1'b1;
                        out_last <= ((idx + 1'b1) == LAST_IDX);
                    end
                end
                CLEAR: begin
                    clear <= 1'b0;
                    idx   <= '0;
                    state <= WAIT_LOW;
                end
                WAIT_LOW: if (!full) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tally_reporter.sv
// Randomized self-checking bench for tally_reporter against a word-list reference model.
module tb_tally_reporter;
    localparam int W = 8;
    localparam int N = 4;
`ifdef TALLY_REPORTER_SUM_EN
    localparam int NW = 5;
`else
    localparam int NW = 4;
`endif

    logic           clock = 1'b0;
    logic           rst, full, out_ready;
    logic [N*W-1:0] count_bus;
    logic           out_valid, out_last, clear, busy;
    logic [W-1:0]   out_data;
    logic [2:0]     out_idx;

    int checks = 0, errors = 0;
    int got_d[$], got_i[$], got_l[$];
    int stall_bad, held1, first_c, n_cyc;
    bit tmo;

    tally_reporter dut (
        .clock(clock), .rst(rst), .full(full), .count_bus(count_bus),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .clear(clear), .busy(busy)
    );

    always #5 clock = ~clock;

    // Reference: word k is counter k of the captured bus; trailer is the byte-wrapped sum.
    function automatic int model_word(input logic [N*W-1:0] cb, input int k);
        int s = 0;
        if (k < N) return int'(cb[k*W +: W]);
        for (int i = 0; i < N; i++) s += int'(cb[i*W +: W]);
        return s % (1 << W);
    endfunction

    // Drives out_ready and records every accepted word; ready_pct < 0 stalls 3 cycles at idx 1.
    task automatic run_report(input int ready_pct, input bit scramble, input bit drop_full);
        bit pv = 0, pr = 0, done = 0;
        int pd = 0, pi = 0, stall_left = 3;
        got_d.delete(); got_i.delete(); got_l.delete();
        stall_bad = 0; held1 = 0; first_c = -1; n_cyc = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clock);
            if (pv && !pr && (out_valid !== 1'b1 || int'(out_data) != pd || int'(out_idx) != pi))
                stall_bad++;
            if (out_valid === 1'b1) begin
                if (first_c < 0) begin
                    first_c = c;
                    if (scramble)  count_bus = '1;
                    if (drop_full) full = 1'b0;
                end
                if (out_idx == 3'd1) held1++;
                if (ready_pct < 0) begin
                    out_ready = !(out_idx == 3'd1 && stall_left > 0);
                    if (!out_ready) stall_left--;
                end else out_ready = ($urandom_range(99) < ready_pct);
                pv = 1; pr = out_ready; pd = int'(out_data); pi = int'(out_idx);
                if (out_ready) begin
                    got_d.push_back(int'(out_data));
                    got_i.push_back(int'(out_idx));
                    got_l.push_back(int'(out_last));
                    if (out_last) begin done = 1; n_cyc = c + 1; end
                end
            end else begin
                out_ready = 1'($urandom_range(1));
                pv = 0;
            end
        end
        tmo = !done;
    endtask

    task automatic go_idle();
        full = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset();
        rst = 1'b1; full = 1'b0; out_ready = 1'b0; count_bus = '0;
        @(negedge clock);
        checks++;
        if ({out_valid, out_last, clear, busy} !== 4'b0) begin
            errors++; $display("FAIL reset_flags: got %b, required 0000", {out_valid, out_last, clear, busy});
        end
        checks++;
        if ({out_data, out_idx} !== 11'd0) begin
            errors++; $display("FAIL reset_data: got data=%0d idx=%0d, required 0/0", out_data, out_idx);
        end
        rst = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL idle_no_full: got busy=%b valid=%b, required 0/0", busy, out_valid);
        end
    endtask

    task automatic test_basic();
        logic [N*W-1:0] cb = {8'd4, 8'd3, 8'd2, 8'd1};
        count_bus = cb; full = 1'b1;
        run_report(100, 0, 0);
        checks++;
        if (tmo || n_cyc != NW || first_c != 0) begin
            errors++; $display("FAIL basic_timing: got timeout=%0d cycles=%0d first=%0d, required 0/%0d/0", tmo, n_cyc, first_c, NW);
        end
        for (int k = 0; k < NW; k++) begin
            checks++;
            if (k >= got_d.size() || got_d[k] != model_word(cb, k) || got_i[k] != k || got_l[k] != int'(k == NW-1)) begin
                errors++; $display("FAIL basic_word%0d: got %0d words, required data=%0d idx=%0d", k, got_d.size(), model_word(cb, k), k);
            end
        end
        @(negedge clock);
        checks++;
        if (clear !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL basic_clear: got clear=%b valid=%b busy=%b, required 1/0/1", clear, out_valid, busy);
        end
        @(negedge clock);
        checks++;
        if (clear !== 1'b0) begin
            errors++; $display("FAIL basic_clear_len: got clear=%b, required 0", clear);
        end
        go_idle();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL basic_idle: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_backpressure();
        logic [N*W-1:0] cb = {8'd4, 8'd3, 8'd2, 8'd1};
        count_bus = cb; full = 1'b1;
        run_report(-1, 0, 0);
        checks++;
        if (tmo || held1 != 4 || stall_bad != 0 || got_d.size() != NW) begin
            errors++; $display("FAIL stall_hold: got timeout=%0d held=%0d unstable=%0d words=%0d, required 0/4/0/%0d", tmo, held1, stall_bad, got_d.size(), NW);
        end
        for (int k = 0; k < NW && k < got_d.size(); k++) begin
            checks++;
            if (got_d[k] != model_word(cb, k) || got_i[k] != k) begin
                errors++; $display("FAIL stall_word%0d: got data=%0d idx=%0d, required %0d/%0d", k, got_d[k], got_i[k], model_word(cb, k), k);
            end
        end
        repeat (2) @(negedge clock);
        go_idle();
    endtask

    task automatic test_snapshot();
        logic [N*W-1:0] cb = {8'd4, 8'd3, 8'd2, 8'd1};
        count_bus = cb; full = 1'b1;
        run_report(60, 1, 0);
        checks++;
        if (tmo || got_d.size() != NW || stall_bad != 0) begin
            errors++; $display("FAIL snap_count: got timeout=%0d words=%0d unstable=%0d, required 0/%0d/0", tmo, got_d.size(), stall_bad, NW);
        end
        for (int k = 0; k < NW && k < got_d.size(); k++) begin
            checks++;
            if (got_d[k] != model_word(cb, k)) begin
                errors++; $display("FAIL snap_word%0d: got %0d, required %0d", k, got_d[k], model_word(cb, k));
            end
        end
        repeat (2) @(negedge clock);
        go_idle();
    endtask

    task automatic test_wait_low();
        logic [N*W-1:0] cb = 32'($urandom);
        count_bus = cb; full = 1'b1;
        run_report(100, 0, 0);
        repeat (2) @(negedge clock);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            checks++;
            if (busy !== 1'b1 || out_valid !== 1'b0 || clear !== 1'b0) begin
                errors++; $display("FAIL wait_low_c%0d: got busy=%b valid=%b clear=%b, required 1/0/0", c, busy, out_valid, clear);
            end
        end
        full = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL wait_low_exit: got busy=%b, required 0", busy);
        end
        cb = 32'($urandom); count_bus = cb; full = 1'b1;
        run_report(100, 0, 0);
        checks++;
        if (tmo || got_d.size() != NW || got_d[NW-1] != model_word(cb, NW-1) || first_c != 0) begin
            errors++; $display("FAIL retrigger: got timeout=%0d words=%0d first=%0d, required 0/%0d/0", tmo, got_d.size(), first_c, NW);
        end
        repeat (2) @(negedge clock);
        go_idle();
    endtask

    task automatic test_reset_mid();
        int clears = 0;
        bit seen = 0;
        count_bus = 32'($urandom); full = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clock);
            if (out_valid === 1'b1 && out_idx == 3'd2) seen = 1;
        end
        rst = 1'b1; full = 1'b0;
        @(negedge clock);
        checks++;
        if (!seen || out_valid !== 1'b0 || clear !== 1'b0 || busy !== 1'b0 || out_idx !== 3'd0) begin
            errors++; $display("FAIL reset_mid: got seen=%0d valid=%b clear=%b busy=%b idx=%0d, required 1/0/0/0/0", seen, out_valid, clear, busy, out_idx);
        end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (clear === 1'b1) clears++;
        end
        checks++;
        if (clears != 0) begin
            errors++; $display("FAIL reset_mid_clear: got %0d clear pulses, required 0", clears);
        end
    endtask

    task automatic test_sum();
        logic [N*W-1:0] cb = {8'hFF, 8'h02, 8'h00, 8'h01};
        count_bus = cb; full = 1'b1;
        run_report(100, 0, 0);
        checks++;
        if (tmo || got_d.size() != NW || got_i[NW-1] != NW-1 || got_l[NW-1] != 1) begin
            errors++; $display("FAIL sum_shape: got timeout=%0d words=%0d, required 0/%0d with last on idx %0d", tmo, got_d.size(), NW, NW-1);
        end
        for (int k = 0; k < NW && k < got_d.size(); k++) begin
            checks++;
            if (got_d[k] != model_word(cb, k) || got_l[k] != int'(k == NW-1)) begin
                errors++; $display("FAIL sum_word%0d: got data=%0d last=%0d, required %0d/%0d", k, got_d[k], got_l[k], model_word(cb, k), k == NW-1);
            end
        end
        repeat (2) @(negedge clock);
        go_idle();
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            logic [N*W-1:0] cb = 32'($urandom);
            count_bus = cb; full = 1'b1;
            run_report(int'($urandom_range(100, 30)), 1'($urandom_range(1)), 1'($urandom_range(1)));
            checks++;
            if (tmo || got_d.size() != NW || stall_bad != 0 || first_c != 0) begin
                errors++; $display("FAIL rand%0d_shape: got timeout=%0d words=%0d unstable=%0d first=%0d", it, tmo, got_d.size(), stall_bad, first_c);
            end
            for (int k = 0; k < NW && k < got_d.size(); k++) begin
                checks++;
                if (got_d[k] != model_word(cb, k) || got_i[k] != k || got_l[k] != int'(k == NW-1)) begin
                    errors++; $display("FAIL rand%0d_word%0d: got data=%0d idx=%0d last=%0d, required %0d/%0d/%0d", it, k, got_d[k], got_i[k], got_l[k], model_word(cb, k), k, k == NW-1);
                end
            end
            @(negedge clock);
            checks++;
            if (clear !== 1'b1) begin
                errors++; $display("FAIL rand%0d_clear: got %b, required 1", it, clear);
            end
            @(negedge clock);
            go_idle();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_snapshot();
        test_wait_low();
        test_reset_mid();
        test_sum();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
